alu_muldiv: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 60 ++++++
 rtl/alu_muldiv.sv | 139 +++++++++++++
 tb/tb_alu_muldiv.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: opcodes, FSM states, step count.
package alu_pkg;

    localparam int W     = 32;
    localparam int STEPS = 32;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_MUL  = 4'b0010;
    localparam logic [3:0] SEL_DIV  = 4'b0011;
    localparam logic [3:0] SEL_SLL  = 4'b0100;
    localparam logic [3:0] SEL_SRL  = 4'b0101;
    localparam logic [3:0] SEL_ROL  = 4'b0110;
    localparam logic [3:0] SEL_ROR  = 4'b0111;
    localparam logic [3:0] SEL_AND  = 4'b1000;
    localparam logic [3:0] SEL_OR   = 4'b1001;
    localparam logic [3:0] SEL_XOR  = 4'b1010;
    localparam logic [3:0] SEL_NOR  = 4'b1011;
    localparam logic [3:0] SEL_NAND = 4'b1100;
    localparam logic [3:0] SEL_XNOR = 4'b1101;
    localparam logic [3:0] SEL_GT   = 4'b1110;
    localparam logic [3:0] SEL_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// 64-bit iterative datapath: shift-add multiply / restoring divide.
// res_*_o show the accumulator value after the current step.
module alu_muldiv_iter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         step_i,
    input  logic         op_div_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_hi_o,
    output logic [W-1:0] res_lo_o
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q;
    logic           div_q;
    logic [W:0]     add;
    logic [W:0]     trial;
    logic [W-1:0]   diff;

    // acc = {hi, lo}: product halves, or {remainder, quotient}
    always_comb begin
        acc_d = acc_q;
        add   = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
        trial = {acc_q[2*W-1:W], acc_q[W-1]};
        diff  = trial[W-1:0] - b_q;
        if (div_q) begin
            if (trial >= {1'b0, b_q})
                acc_d = {diff, acc_q[W-2:0], 1'b1};
            else
                acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            if (acc_q[0])
                acc_d = {add, acc_q[W-1:1]};
            else
                acc_d = {1'b0, acc_q[2*W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= {{W{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= op_div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    assign res_hi_o = acc_d[2*W-1:W];
    assign res_lo_o = acc_d[W-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked ALU with 32-step iterative multiply/divide.
// Define ALU_MULDIV_HI_EN to expose the upper product / remainder on `hi`.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   sel,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] out,
    output logic         carry
`ifdef ALU_MULDIV_HI_EN
    ,
    output logic [W-1:0] hi
`endif
);

    state_e       state_q;
    logic [4:0]   cnt_q;
    logic         div_q;
    logic         bz_q;
    logic [W-1:0] out_q;
    logic         carry_q;
    logic [W-1:0] s_out;
    logic         s_carry;
    logic [W:0]   sum;
    logic [5:0]   sh;
    logic [5:0]   shc;
    logic         is_md;
    logic         start;
    logic [W-1:0] hi_nx;
    logic [W-1:0] lo_nx;

    assign is_md = (sel == SEL_MUL) || (sel == SEL_DIV);
    assign start = (state_q == ST_IDLE) && req_valid && is_md;

    always_comb begin
        s_out   = '0;
        s_carry = 1'b0;
        sum     = {1'b0, A} + {1'b0, B};
        sh      = {1'b0, B[4:0]};
        shc     = 6'd32 - sh;
        unique case (sel)
            SEL_ADD:  begin s_out = sum[W-1:0]; s_carry = sum[W]; end
            SEL_SUB:  begin s_out = A - B; s_carry = (A < B); end
            SEL_MUL:  s_out = '0;
            SEL_DIV:  s_out = '0;
            SEL_SLL:  s_out = A << sh;
            SEL_SRL:  s_out = A >> sh;
            SEL_ROL:  s_out = (A << sh) | (A >> shc);
            SEL_ROR:  s_out = (A >> sh) | (A << shc);
            SEL_AND:  s_out = A & B;
            SEL_OR:   s_out = A | B;
            SEL_XOR:  s_out = A ^ B;
            SEL_NOR:  s_out = ~(A | B);
            SEL_NAND: s_out = ~(A & B);
            SEL_XNOR: s_out = ~(A ^ B);
            SEL_GT:   s_out = {{(W-1){1'b0}}, A > B};
            SEL_EQ:   s_out = {{(W-1){1'b0}}, A == B};
        endcase
    end

    alu_muldiv_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .step_i   (state_q == ST_BUSY),
        .op_div_i (sel == SEL_DIV),
        .a_i      (A),
        .b_i      (B),
        .res_hi_o (hi_nx),
        .res_lo_o (lo_nx)
    );

`ifdef ALU_MULDIV_HI_EN
    logic [W-1:0] hi_q;
    always_ff @(posedge clk) begin
        if (rst)
            hi_q <= '0;
        else if (state_q == ST_IDLE && req_valid && !is_md)
            hi_q <= '0;
        else if (state_q == ST_BUSY && cnt_q == 5'(STEPS-1))
            hi_q <= hi_nx;
    end
    assign hi = hi_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (req_valid) begin
                    if (is_md) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= '0;
                        div_q   <= (sel == SEL_DIV);
                        bz_q    <= (B == '0);
                    end else begin
                        state_q <= ST_DONE;
                        out_q   <= s_out;
                        carry_q <= s_carry;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(STEPS-1)) begin
                        state_q <= ST_DONE;
                        if (div_q) begin
                            out_q   <= bz_q ? '1 : lo_nx;
                            carry_q <= bz_q;
                        end else begin
                            out_q   <= lo_nx;
                            carry_q <= |hi_nx;
                        end
                    end
                end
                ST_DONE: if (rsp_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] out;
    logic        carry;
    logic [31:0] hi;

    int total = 0;
    int passed = 0;
    int failed = 0;

    alu_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .out       (out),
        .carry     (carry)
`ifdef ALU_MULDIV_HI_EN
        ,
        .hi        (hi)
`endif
    );

`ifndef ALU_MULDIV_HI_EN
    assign hi = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, b,
                                  input logic [3:0] s,
                                  output logic [31:0] o,
                                  output logic c,
                                  output logic [31:0] h);
        logic [63:0] w;
        int n;
        n = int'(b[4:0]);
        o = 0; c = 0; h = 0;
        case (s)
            SEL_ADD: begin w = 64'(a) + 64'(b); o = w[31:0]; c = w[32]; end
            SEL_SUB: begin o = a - b; c = a < b; end
            SEL_MUL: begin
                w = 64'(a) * 64'(b);
                o = w[31:0]; h = w[63:32]; c = h != 0;
            end
            SEL_DIV: begin
                if (b == 0) begin o = 32'hFFFFFFFF; c = 1; h = a; end
                else begin o = a / b; h = a % b; end
            end
            SEL_SLL:  o = a << n;
            SEL_SRL:  o = a >> n;
            SEL_ROL:  o = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
            SEL_ROR:  o = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
            SEL_AND:  o = a & b;
            SEL_OR:   o = a | b;
            SEL_XOR:  o = a ^ b;
            SEL_NOR:  o = ~(a | b);
            SEL_NAND: o = ~(a & b);
            SEL_XNOR: o = ~(a ^ b);
            SEL_GT:   o = (a > b) ? 1 : 0;
            default:  o = (a == b) ? 1 : 0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] s);
        return (s == SEL_MUL || s == SEL_DIV) ? 32 : 0;
    endfunction

    // one full transaction; bp = cycles of held-off rsp_ready
    task automatic run(input logic [31:0] a, b, input logic [3:0] s,
                       input int bp);
        logic [31:0] eo, eh;
        logic ec;
        int n;
        model(a, b, s, eo, ec, eh);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1; A = a; B = b; sel = s; rsp_ready = 0;
        @(posedge clk); #1;
        req_valid = 0; A = $urandom; B = $urandom; sel = 4'($urandom);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(lat_of(s)));
        chk("out", 64'(out), 64'(eo));
        chk("carry", 64'(carry), 64'(ec));
`ifdef ALU_MULDIV_HI_EN
        chk("hi", 64'(hi), 64'(eh));
`endif
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'({rsp_valid, req_ready}), 64'b10);
            chk("bp_out", 64'({carry, out}), 64'({ec, eo}));
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("after_hs", 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    initial begin
        logic [31:0] ra, rb, eo, eh, o0;
        logic [3:0]  rs;
        logic        ec, c0;
        int          seen;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_out", 64'({carry, out}), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);

        run(32'h00EF2598, 32'h00ABC999, SEL_ADD, 0);
        run(32'h00010000, 32'h00010000, SEL_MUL, 0);
        run(32'd100, 32'd7, SEL_DIV, 0);
        run(32'd5, 32'd0, SEL_DIV, 0);
        run(32'hFFFFFFFF, 32'd1, SEL_ADD, 0);
        run(32'd3, 32'd4, SEL_SUB, 0);
        run(32'h80000001, 32'd0, SEL_ROL, 0);
        run(32'h80000001, 32'd31, SEL_ROR, 0);

        // backpressure with a pending request held by the initiator
        run(32'd1234567, 32'd89, SEL_MUL, 5);
        model(32'd77, 32'd77, SEL_EQ, eo, ec, eh);
        req_valid = 1; A = 32'd77; B = 32'd77; sel = SEL_EQ;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("accept_after_hs", 64'({rsp_valid, out}), 64'({1'b1, eo}));
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;

        // reset in the middle of a divide
        req_valid = 1; A = 32'd1000; B = 32'd3; sel = SEL_DIV;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (10) @(posedge clk);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_mid_valid", 64'({rsp_valid, req_ready}), 64'b01);
        chk("rst_mid_out", 64'({carry, out}), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        seen = 0;
        rsp_ready = 1;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        rsp_ready = 0;
        chk("no_rsp_after_rst", 64'(seen), 64'd0);

        // back-to-back sweep of single-cycle ops, accepted every 2 cycles
        rsp_ready = 1;
        for (int s = 0; s < 16; s++) begin
            rs = 4'(s);
            if (rs == SEL_MUL || rs == SEL_DIV) continue;
            ra = $urandom; rb = $urandom;
            model(ra, rb, rs, eo, ec, eh);
            req_valid = 1; A = ra; B = rb; sel = rs;
            @(posedge clk); #1;
            req_valid = 0;
            chk("sw_valid", 64'({rsp_valid, req_ready}), 64'b10);
            chk("sw_res", 64'({carry, out}), 64'({ec, eo}));
            o0 = out; c0 = carry;
            @(posedge clk); #1;
            chk("sw_ready", 64'({rsp_valid, req_ready}), 64'b01);
        end
        rsp_ready = 0;
        run(32'hDEADBEEF, 32'h12345, SEL_MUL, 0);
        run(32'hDEADBEEF, 32'h12345, SEL_DIV, 0);

        // random transactions
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: rb = 0;
                1: rb = 32'($urandom_range(1, 64));
                2: rb = ra;
                default: rb = $urandom;
            endcase
            run(ra, rb, rs, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
